// File: rtl/axi_pkg.sv
// Minimal AXI response encoding shared by the RAB configuration logic.
package axi_pkg;

  typedef logic [1:0] resp_t;

  localparam resp_t RESP_OKAY   = 2'b00;
  localparam resp_t RESP_EXOKAY = 2'b01;
  localparam resp_t RESP_SLVERR = 2'b10;
  localparam resp_t RESP_DECERR = 2'b11;

endpackage

// File: rtl/rab_cfg_pkg.sv
// Descriptor/response types, register offsets and sequencer state encodings
// for programming one RAB translation slice.
package rab_cfg_pkg;

  localparam int DESC_AW = 64;
  localparam int DESC_OW = 32;

  localparam logic [7:0] RAB_OFFS_FIRST = 8'h00;
  localparam logic [7:0] RAB_OFFS_LAST  = 8'h08;
  localparam logic [7:0] RAB_OFFS_BASE  = 8'h10;
  localparam logic [7:0] RAB_OFFS_FLAGS = 8'h18;

  localparam int RAB_FLAG_VALID = 0;
  localparam int RAB_FLAG_RD    = 1;
  localparam int RAB_FLAG_WR    = 2;

  typedef enum logic [1:0] {
    FLD_FIRST = 2'd0,
    FLD_LAST  = 2'd1,
    FLD_BASE  = 2'd2,
    FLD_FLAGS = 2'd3
  } rab_field_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ADDR = 2'd1,
    ST_RESP = 2'd2,
    ST_DONE = 2'd3
  } rab_state_e;

  typedef struct packed {
    logic [DESC_OW-1:0] slice_offs;
    logic [DESC_AW-1:0] first;
    logic [DESC_AW-1:0] last;
    logic [DESC_AW-1:0] base;
    logic [2:0]         flags;
  } rab_slice_desc_t;

  typedef struct packed {
    logic           err;
    logic           timeout;
    axi_pkg::resp_t resp;
    logic [7:0]     n_writes;
  } rab_slice_rsp_t;

  function automatic int words_per_field(input int aw, input int dw);
    return (aw + dw - 1) / dw;
  endfunction

endpackage

// File: rtl/rab_slice_programmer_if.sv
// Write-only AXI4-Lite configuration bus between the slice programmer and rab_conf.
interface rab_slice_programmer_if
  import axi_pkg::*;
#(
  parameter int LITE_AW = 32,
  parameter int LITE_DW = 32
) ();

  logic [LITE_AW-1:0]   aw_addr;
  logic [2:0]           aw_prot;
  logic                 aw_valid;
  logic                 aw_ready;
  logic [LITE_DW-1:0]   w_data;
  logic [LITE_DW/8-1:0] w_strb;
  logic                 w_valid;
  logic                 w_ready;
  resp_t                b_resp;
  logic                 b_valid;
  logic                 b_ready;

  modport master (
    output aw_addr, aw_prot, aw_valid, w_data, w_strb, w_valid, b_ready,
    input  aw_ready, w_ready, b_resp, b_valid
  );

  modport slave (
    input  aw_addr, aw_prot, aw_valid, w_data, w_strb, w_valid, b_ready,
    output aw_ready, w_ready, b_resp, b_valid
  );

endinterface

// File: rtl/rab_slice_programmer.sv
// Programs one RAB slice (first/last/base split into LITE_DW words, then flags)
// over AXI4-Lite, one outstanding write at a time, with error and timeout abort.
module rab_slice_programmer
  import axi_pkg::*;
  import rab_cfg_pkg::*;
#(
  parameter int                 AXI_AW         = 64,
  parameter int                 LITE_AW        = 32,
  parameter int                 LITE_DW        = 32,
  parameter logic [LITE_AW-1:0] RAB_CFG_BASE   = LITE_AW'(32'hA800_0000),
  parameter int unsigned        TIMEOUT_CYCLES = 1024
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic                          desc_valid_i,
  output logic                          desc_ready_o,
  input  rab_slice_desc_t               desc_i,
  output logic                          rsp_valid_o,
  input  logic                          rsp_ready_i,
  output rab_slice_rsp_t                rsp_o,
  rab_slice_programmer_if.master        cfg,
  output logic                          busy_o
);

  localparam int          NW       = words_per_field(AXI_AW, LITE_DW);
  localparam int          FW       = NW * LITE_DW;
  localparam logic [7:0]  NW_M1    = 8'(NW - 1);
  localparam logic [31:0] TMO_LAST = 32'(TIMEOUT_CYCLES - 1);

  rab_state_e      state_q, state_d;
  rab_field_e      field_q, field_d;
  logic [7:0]      word_q, word_d;
  logic            aw_done_q, aw_done_d;
  logic            w_done_q, w_done_d;
  logic [31:0]     tmo_q, tmo_d;
  rab_slice_rsp_t  rsp_q, rsp_d;
  rab_slice_desc_t desc_q, desc_d;

  logic               aw_valid, w_valid, tmo_hit;
  logic [DESC_AW-1:0] fld_sel;
  logic [FW-1:0]      fld_ext;
  logic [LITE_DW-1:0] wdata;
  logic [7:0]         fld_offs;

  assign desc_ready_o = (state_q == ST_IDLE) && !rst_i;
  assign rsp_valid_o  = (state_q == ST_DONE);
  assign busy_o       = (state_q != ST_IDLE);
  assign rsp_o        = rsp_q;

  // Valids come straight from state flops, so they drop the moment reset hits.
  assign aw_valid     = (state_q == ST_ADDR) && !aw_done_q;
  assign w_valid      = (state_q == ST_ADDR) && !w_done_q;
  assign cfg.aw_valid = aw_valid;
  assign cfg.w_valid  = w_valid;
  assign cfg.b_ready  = (state_q == ST_RESP);
  assign cfg.aw_prot  = 3'b000;
  assign cfg.w_strb   = '1;
  assign cfg.w_data   = wdata;
  assign cfg.aw_addr  = RAB_CFG_BASE + LITE_AW'(desc_q.slice_offs) + LITE_AW'(fld_offs)
                      + LITE_AW'(word_q) * LITE_AW'(LITE_DW / 8);

  // Payload depends only on the held descriptor and the field/word counters,
  // which move on B, so it stays stable for the whole ADDR phase.
  always_comb begin
    fld_sel  = desc_q.first;
    fld_offs = RAB_OFFS_FIRST;
    case (field_q)
      FLD_LAST:  begin fld_sel = desc_q.last; fld_offs = RAB_OFFS_LAST;  end
      FLD_BASE:  begin fld_sel = desc_q.base; fld_offs = RAB_OFFS_BASE;  end
      FLD_FLAGS: begin fld_sel = '0;          fld_offs = RAB_OFFS_FLAGS; end
      default:   begin fld_sel = desc_q.first; fld_offs = RAB_OFFS_FIRST; end
    endcase
    fld_ext             = '0;
    fld_ext[AXI_AW-1:0] = fld_sel[AXI_AW-1:0];
    wdata               = fld_ext[int'(word_q) * LITE_DW +: LITE_DW];
    if (field_q == FLD_FLAGS) wdata = LITE_DW'(desc_q.flags);
  end

  always_comb begin
    state_d   = state_q;
    field_d   = field_q;
    word_d    = word_q;
    aw_done_d = aw_done_q;
    w_done_d  = w_done_q;
    tmo_d     = tmo_q;
    rsp_d     = rsp_q;
    desc_d    = desc_q;
    tmo_hit   = (TIMEOUT_CYCLES != 0) && (tmo_q == TMO_LAST);

    unique case (state_q)
      ST_IDLE: begin
        if (desc_valid_i && desc_ready_o) begin
          desc_d    = desc_i;
          field_d   = FLD_FIRST;
          word_d    = '0;
          aw_done_d = 1'b0;
          w_done_d  = 1'b0;
          tmo_d     = '0;
          rsp_d     = '0;
          state_d   = ST_ADDR;
        end
      end
      ST_ADDR: begin
        tmo_d     = tmo_q + 32'd1;
        aw_done_d = aw_done_q | (aw_valid & cfg.aw_ready);
        w_done_d  = w_done_q  | (w_valid  & cfg.w_ready);
        if (aw_done_d && w_done_d) begin
          aw_done_d = 1'b0;
          w_done_d  = 1'b0;
          tmo_d     = '0;
          state_d   = ST_RESP;
        end else if (tmo_hit) begin
          rsp_d.err     = 1'b1;
          rsp_d.timeout = 1'b1;
          state_d       = ST_DONE;
        end
      end
      ST_RESP: begin
        tmo_d = tmo_q + 32'd1;
        if (cfg.b_valid) begin
          tmo_d = '0;
          if (cfg.b_resp[1]) begin
            // SLVERR/DECERR: abandon the rest so the flags never enable a half-written slice.
            rsp_d.err  = 1'b1;
            rsp_d.resp = cfg.b_resp;
            state_d    = ST_DONE;
          end else begin
            rsp_d.n_writes = rsp_q.n_writes + 8'd1;
            if (field_q == FLD_FLAGS) begin
              state_d = ST_DONE;
            end else begin
              state_d = ST_ADDR;
              if (word_q == NW_M1) begin
                word_d  = '0;
                field_d = rab_field_e'(field_q + 2'd1);
              end else begin
                word_d  = word_q + 8'd1;
              end
            end
          end
        end else if (tmo_hit) begin
          rsp_d.err     = 1'b1;
          rsp_d.timeout = 1'b1;
          state_d       = ST_DONE;
        end
      end
      ST_DONE: begin
        if (rsp_ready_i) state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q   <= ST_IDLE;
      field_q   <= FLD_FIRST;
      word_q    <= '0;
      aw_done_q <= 1'b0;
      w_done_q  <= 1'b0;
      tmo_q     <= '0;
      rsp_q     <= '0;
    end else begin
      state_q   <= state_d;
      field_q   <= field_d;
      word_q    <= word_d;
      aw_done_q <= aw_done_d;
      w_done_q  <= w_done_d;
      tmo_q     <= tmo_d;
      rsp_q     <= rsp_d;
    end
  end

  always_ff @(posedge clk_i) begin
    desc_q <= desc_d;
  end

endmodule

// File: tb/tb_rab_slice_programmer.sv
// Directed bench for rab_slice_programmer: two instances (32- and 64-bit lite data)
// behind simple AXI-Lite slave models with selectable ready behaviour.
module tb_rab_slice_programmer;
  import axi_pkg::*;
  import rab_cfg_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic dv32 = 1'b0, dv64 = 1'b0, rr32 = 1'b0, rr64 = 1'b0;
  rab_slice_desc_t desc = '0;
  logic dr32, dr64, rv32, rv64, busy32, busy64;
  rab_slice_rsp_t rsp32, rsp64;

  rab_slice_programmer_if #(.LITE_AW(32), .LITE_DW(32)) if32 ();
  rab_slice_programmer_if #(.LITE_AW(32), .LITE_DW(64)) if64 ();

  rab_slice_programmer #(.AXI_AW(64), .LITE_AW(32), .LITE_DW(32),
                         .RAB_CFG_BASE(32'hA800_0000), .TIMEOUT_CYCLES(16)) dut32 (
    .clk_i(clk), .rst_i(rst), .desc_valid_i(dv32), .desc_ready_o(dr32), .desc_i(desc),
    .rsp_valid_o(rv32), .rsp_ready_i(rr32), .rsp_o(rsp32), .cfg(if32), .busy_o(busy32));

  rab_slice_programmer #(.AXI_AW(64), .LITE_AW(32), .LITE_DW(64),
                         .RAB_CFG_BASE(32'hA800_0000), .TIMEOUT_CYCLES(1024)) dut64 (
    .clk_i(clk), .rst_i(rst), .desc_valid_i(dv64), .desc_ready_o(dr64), .desc_i(desc),
    .rsp_valid_o(rv64), .rsp_ready_i(rr64), .rsp_o(rsp64), .cfg(if64), .busy_o(busy64));

  int checks = 0;
  int failures = 0;

  task automatic chk_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", tag, act, exp);
    end
  endtask

  // Slave for the 32-bit instance. s_mode: 0 always ready, 1 staggered/alternating, 2 AW never ready.
  int s_mode = 0;
  int berr_at = -1;
  bit slv_clr = 1'b0;
  int stab_err = 0;
  logic [63:0] a32_q[$], d32_q[$], a64_q[$], d64_q[$];

  initial begin : slave32
    bit aw_f, w_f, b_f, aw_got, w_got, prev_awv, prev_wv;
    int hold, pairs;
    logic [31:0] prev_addr, prev_data;
    if32.aw_ready = 1'b0; if32.w_ready = 1'b0; if32.b_valid = 1'b0; if32.b_resp = RESP_OKAY;
    aw_got = 0; w_got = 0; prev_awv = 0; prev_wv = 0; hold = 0; pairs = 0;
    prev_addr = '0; prev_data = '0;
    forever begin
      @(negedge clk);
      aw_f = if32.aw_valid && if32.aw_ready;
      w_f  = if32.w_valid && if32.w_ready;
      b_f  = if32.b_valid && if32.b_ready;
      if (prev_awv && if32.aw_valid && if32.aw_addr !== prev_addr) stab_err++;
      if (prev_wv && if32.w_valid && if32.w_data !== prev_data) stab_err++;
      prev_awv = if32.aw_valid && !if32.aw_ready; prev_addr = if32.aw_addr;
      prev_wv  = if32.w_valid && !if32.w_ready;   prev_data = if32.w_data;
      if (aw_f) a32_q.push_back(64'(if32.aw_addr));
      if (w_f)  d32_q.push_back(64'(if32.w_data));
      @(posedge clk); #1;
      if (rst || slv_clr) begin
        slv_clr = 1'b0; if32.b_valid = 1'b0; aw_got = 0; w_got = 0; hold = 0; pairs = 0;
        prev_awv = 0; prev_wv = 0;
        if (!rst) begin a32_q.delete(); d32_q.delete(); stab_err = 0; end
      end else begin
        if (b_f) if32.b_valid = 1'b0;
        if (aw_f) aw_got = 1;
        if (w_f)  w_got = 1;
        if (aw_got && w_got && !if32.b_valid) begin
          if32.b_valid = 1'b1;
          if32.b_resp  = (pairs == berr_at) ? RESP_SLVERR : RESP_OKAY;
          pairs++; aw_got = 0; w_got = 0;
        end
        hold = (if32.aw_valid || if32.w_valid) ? hold + 1 : 0;
        case (s_mode)
          1: begin
            if (pairs[0]) begin if32.aw_ready = 1'b1; if32.w_ready = 1'b1; end
            else begin if32.w_ready = (hold >= 1); if32.aw_ready = (hold >= 4); end
          end
          2:       begin if32.aw_ready = 1'b0; if32.w_ready = 1'b1; end
          default: begin if32.aw_ready = 1'b1; if32.w_ready = 1'b1; end
        endcase
      end
    end
  end

  initial begin : slave64
    bit aw_f, w_f, b_f, ag, wg;
    if64.aw_ready = 1'b1; if64.w_ready = 1'b1; if64.b_valid = 1'b0; if64.b_resp = RESP_OKAY;
    ag = 0; wg = 0;
    forever begin
      @(negedge clk);
      aw_f = if64.aw_valid && if64.aw_ready;
      w_f  = if64.w_valid && if64.w_ready;
      b_f  = if64.b_valid && if64.b_ready;
      if (aw_f) a64_q.push_back(64'(if64.aw_addr));
      if (w_f)  d64_q.push_back(if64.w_data);
      @(posedge clk); #1;
      if (rst) begin
        if64.b_valid = 1'b0; ag = 0; wg = 0;
      end else begin
        if (b_f) if64.b_valid = 1'b0;
        ag = ag | aw_f; wg = wg | w_f;
        if (ag && wg && !if64.b_valid) begin if64.b_valid = 1'b1; ag = 0; wg = 0; end
      end
    end
  end

  logic [63:0] ea32 [7] = '{64'hA800_1000, 64'hA800_1004, 64'hA800_1008, 64'hA800_100C,
                            64'hA800_1010, 64'hA800_1014, 64'hA800_1018};
  logic [63:0] ed32 [7] = '{64'h1, 64'h0, 64'hFFFF_FFFF, 64'h000F_FFFF, 64'h1, 64'h0, 64'h7};
  logic [63:0] ea64 [4] = '{64'hA800_1000, 64'hA800_1008, 64'hA800_1010, 64'hA800_1018};
  logic [63:0] ed64 [4] = '{64'h1, 64'h000F_FFFF_FFFF_FFFF, 64'h1, 64'h7};

  task automatic start_desc(input bit s64, input rab_slice_desc_t d);
    bit ok;
    ok = 0;
    @(posedge clk); #1;
    desc = d;
    if (s64) dv64 = 1'b1; else dv32 = 1'b1;
    for (int n = 0; n < 50; n++) begin
      @(negedge clk);
      if (s64 ? dr64 : dr32) begin ok = 1; break; end
    end
    @(posedge clk); #1;
    dv32 = 1'b0; dv64 = 1'b0;
    chk_eq("desc_accept", 64'(ok), 64'd1);
  endtask

  task automatic finish_desc(input bit s64, output int lat, output int awv, output rab_slice_rsp_t r);
    logic v;
    lat = 0; awv = 0; v = 1'b0;
    while (!v && lat < 200) begin
      @(negedge clk);
      lat++;
      if (s64 ? if64.aw_valid : if32.aw_valid) awv++;
      v = s64 ? rv64 : rv32;
    end
    chk_eq("rsp_valid_seen", 64'(v), 64'd1);
    r = s64 ? rsp64 : rsp32;
    if (s64) rr64 = 1'b1; else rr32 = 1'b1;
    @(posedge clk); #1;
    rr32 = 1'b0; rr64 = 1'b0;
    @(negedge clk);
    chk_eq("b2b_desc_ready", 64'(s64 ? dr64 : dr32), 64'd1);
    chk_eq("rsp_valid_drop", 64'(s64 ? rv64 : rv32), 64'd0);
  endtask

  task automatic check_logs32(input string tag);
    logic [63:0] a, d;
    chk_eq({tag, "_aw_count"}, 64'(a32_q.size()), 64'd7);
    chk_eq({tag, "_w_count"},  64'(d32_q.size()), 64'd7);
    for (int i = 0; i < 7; i++) begin
      a = (i < a32_q.size()) ? a32_q[i] : '1;
      d = (i < d32_q.size()) ? d32_q[i] : '1;
      chk_eq($sformatf("%s_addr%0d", tag, i), a, ea32[i]);
      chk_eq($sformatf("%s_data%0d", tag, i), d, ed32[i]);
    end
  endtask

  initial begin : stim
    rab_slice_desc_t d;
    rab_slice_rsp_t r;
    int lat, awv;
    bit saw_flags;
    logic [63:0] a, dd;

    d.slice_offs = 32'h1000;
    d.first      = 64'h1;
    d.last       = 64'h000F_FFFF_FFFF_FFFF;
    d.base       = 64'h1;
    d.flags      = 3'b111;

    #2;
    chk_eq("rst_desc_ready", 64'(dr32), 64'd0);
    chk_eq("rst_busy",       64'(busy32), 64'd0);
    chk_eq("rst_rsp_valid",  64'(rv32), 64'd0);
    chk_eq("rst_aw_valid",   64'(if32.aw_valid), 64'd0);
    chk_eq("rst_w_valid",    64'(if32.w_valid), 64'd0);
    chk_eq("rst_b_ready",    64'(if32.b_ready), 64'd0);
    chk_eq("rst_rsp",        64'(rsp32), 64'd0);
    @(negedge clk); @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk_eq("idle_desc_ready", 64'(dr32), 64'd1);

    // Always-ready slave, 32-bit data
    s_mode = 0; berr_at = -1; slv_clr = 1'b1;
    start_desc(1'b0, d);
    finish_desc(1'b0, lat, awv, r);
    chk_eq("s1_latency", 64'(lat), 64'd15);
    chk_eq("s1_err", 64'(r.err), 64'd0);
    chk_eq("s1_timeout", 64'(r.timeout), 64'd0);
    chk_eq("s1_n_writes", 64'(r.n_writes), 64'd7);
    check_logs32("s1");

    // Staggered W/AW readiness
    s_mode = 1; berr_at = -1; slv_clr = 1'b1;
    start_desc(1'b0, d);
    finish_desc(1'b0, lat, awv, r);
    chk_eq("s3_err", 64'(r.err), 64'd0);
    chk_eq("s3_n_writes", 64'(r.n_writes), 64'd7);
    chk_eq("s3_stable", 64'(stab_err), 64'd0);
    check_logs32("s3");

    // SLVERR on the third B
    s_mode = 0; berr_at = 2; slv_clr = 1'b1;
    start_desc(1'b0, d);
    finish_desc(1'b0, lat, awv, r);
    chk_eq("s4_err", 64'(r.err), 64'd1);
    chk_eq("s4_resp", 64'(r.resp), 64'(RESP_SLVERR));
    chk_eq("s4_n_writes", 64'(r.n_writes), 64'd2);
    chk_eq("s4_timeout", 64'(r.timeout), 64'd0);
    chk_eq("s4_aw_count", 64'(a32_q.size()), 64'd3);
    saw_flags = 0;
    foreach (a32_q[i]) if (a32_q[i] == 64'hA800_1018) saw_flags = 1;
    chk_eq("s4_no_flags_write", 64'(saw_flags), 64'd0);

    // AW never ready -> timeout after 16 cycles
    s_mode = 2; berr_at = -1; slv_clr = 1'b1;
    start_desc(1'b0, d);
    finish_desc(1'b0, lat, awv, r);
    chk_eq("s5_aw_valid_cycles", 64'(awv), 64'd16);
    chk_eq("s5_latency", 64'(lat), 64'd17);
    chk_eq("s5_timeout", 64'(r.timeout), 64'd1);
    chk_eq("s5_err", 64'(r.err), 64'd1);
    chk_eq("s5_n_writes", 64'(r.n_writes), 64'd0);
    chk_eq("s5_aw_count", 64'(a32_q.size()), 64'd0);

    // Reset during the 4th write's ADDR phase
    s_mode = 0; berr_at = -1; slv_clr = 1'b1;
    start_desc(1'b0, d);
    repeat (7) @(negedge clk);
    chk_eq("s6_in_addr4", 64'(if32.aw_valid), 64'd1);
    chk_eq("s6_addr4", 64'(if32.aw_addr), 64'hA800_100C);
    #2 rst = 1'b1;
    #1;
    chk_eq("s6_rst_aw_valid", 64'(if32.aw_valid), 64'd0);
    chk_eq("s6_rst_w_valid",  64'(if32.w_valid), 64'd0);
    chk_eq("s6_rst_b_ready",  64'(if32.b_ready), 64'd0);
    chk_eq("s6_rst_desc_ready", 64'(dr32), 64'd0);
    chk_eq("s6_rst_rsp_valid", 64'(rv32), 64'd0);
    chk_eq("s6_rst_busy", 64'(busy32), 64'd0);
    chk_eq("s6_rst_rsp", 64'(rsp32), 64'd0);
    @(negedge clk);
    rst = 1'b0; slv_clr = 1'b1;
    start_desc(1'b0, d);
    finish_desc(1'b0, lat, awv, r);
    chk_eq("s6_latency", 64'(lat), 64'd15);
    chk_eq("s6_n_writes", 64'(r.n_writes), 64'd7);
    check_logs32("s6");

    // 64-bit lite data on the second instance
    a64_q.delete(); d64_q.delete();
    start_desc(1'b1, d);
    finish_desc(1'b1, lat, awv, r);
    chk_eq("s2_latency", 64'(lat), 64'd9);
    chk_eq("s2_err", 64'(r.err), 64'd0);
    chk_eq("s2_n_writes", 64'(r.n_writes), 64'd4);
    chk_eq("s2_aw_count", 64'(a64_q.size()), 64'd4);
    for (int i = 0; i < 4; i++) begin
      a  = (i < a64_q.size()) ? a64_q[i] : '1;
      dd = (i < d64_q.size()) ? d64_q[i] : '1;
      chk_eq($sformatf("s2_addr%0d", i), a, ea64[i]);
      chk_eq($sformatf("s2_data%0d", i), dd, ed64[i]);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
